tetromino_shape_matcher: RTL and testbench
==========================================

# tetromino_shape_matcher

Inverse of the tetromino lookup: accepts a 4x4 occupancy bitmap one row per beat over a valid/ready stream. It scans the seven tetromino tables and reports which tetromino index and rotation the bitmap matches exactly, if any. It sits between the board-capture logic and the piece-tracking logic, recovering piece identity from a captured 4x4 window. It instantiates `get_tetromino_info` and drives its index from an internal scan counter.

## Interface
Parameters: none. Types `tetromino_idx_t`, `tetromino_t` and the `TETROMINO_*_IDX` macros come from `GLOBAL.sv`.

Clock and reset:
- clk  in  1  sole clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous and active-low

Row input stream:
- clear  in  1  synchronous abort; return to LOAD, discard rows and result
- row_valid  in  1  row_data valid
- row_ready  out  1  block accepts a row (high only in LOAD)
- row_data  in  4  one bitmap row, top row first; bit 3 = leftmost column

Result stream:
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_found  out  1  1 = exact match found
- res_idx  out  tetromino_idx_t  matched piece; `.data` = `TETROMINO_I_IDX` when not found
- res_rot  out  2  matched rotation 0..3; 0 when not found

## Operation
Table layout:
- Rotation r occupies `tetromino_t` bits [63-16r : 48-16r].
- Within a rotation, row 0 is the most significant nibble.
- The captured bitmap uses the same row/bit order.

States:
- LOAD (reset state):
  - row_ready=1.
  - On row_valid&row_ready, store row_data into row slot row_cnt; row_cnt increments.
  - After slot 3 is stored: row_cnt wraps to 0, piece_cnt=0, go to SCAN.
- SCAN:
  - Each cycle, compare the captured 16-bit bitmap against all 4 rotations of piece piece_cnt in parallel.
  - Scan order, piece_cnt 0..6: I, J, L, O, S, T, Z (mapped to `TETROMINO_*_IDX`).
  - Any hit: latch found=1, idx, and the lowest matching rotation (O always yields rot 0); go to DONE.
  - No hit with piece_cnt=6: latch found=0, idx=I, rot=0; go to DONE.
  - Otherwise piece_cnt+1.
- DONE:
  - res_valid=1; res_* held stable.
  - On res_valid&res_ready, go to LOAD.

Match rules:
- Match is exact positional equality over all 16 bits. No translation, no partial match.
- A bitmap with ≠4 set bits never matches.

Clear and reset:
- clear has priority in every state: next state LOAD, row_cnt=0, res_valid=0. Rows accepted in the clear cycle are dropped.
- rst_n low at any time, including mid-LOAD or mid-SCAN: immediate return to reset values. Partially loaded rows are discarded.

Reset values:
- row_ready=1 (state LOAD).
- res_valid=0, res_found=0, res_idx.data=`TETROMINO_I_IDX`, res_rot=0.
- Internal: row_cnt=0, piece_cnt=0, bitmap=0.

## Timing
- One row accepted per cycle while row_valid=1 in LOAD. Accepting 4 rows takes a minimum of 4 cycles.
- Let T be the cycle of the 4th row handshake:
  - SCAN compares piece k in cycle T+1+k.
  - res_valid rises in cycle T+2+k for a hit on piece k.
  - A miss gives res_valid at T+8.
- Latency bounds: best case I = 2 cycles, worst case Z or no match = 8 cycles after the last row.
- Result handshake in cycle D: row_ready=1 in D+1, res_valid=0 in D+1. There is no bypass, so at most one result per 6 cycles.
- In SCAN and DONE, row_ready=0 and row_valid is ignored.
- res_* must not change while res_valid=1 and res_ready=0.
- Outputs are registered or decoded from state only. There are no combinational paths from row_valid or res_ready to any output.

## Test plan
- I rot 1: rows 0010,0010,0010,0010 -> res_found=1, idx=I, rot=1, res_valid at T+2.
- Z rot 3: rows 0000,0100,1100,1000 -> found=1, idx=Z, rot=3 at T+8. O: rows 0000,0110,0110,0000 -> idx=O, rot=0 at T+5. T rot 2: rows 0000,0000,1110,0100 -> idx=T, rot=2 at T+7.
- No match: rows 1111,1111,0000,0000 -> found=0, idx=I, rot=0 at T+8. All-zero bitmap -> found=0.
- Backpressure: hold res_ready=0 for 5 cycles after res_valid while toggling row_valid -> res_* stable, row_ready=0, no rows taken. Raise res_ready -> row_ready=1 the next cycle.
- Rows with gaps: row_valid pattern 1,0,0,1,1,0,1 carrying I rot 0 rows (0000,1111,0000,0000) -> correct result.
- Abort: pulse rst_n low after 2 rows, and separately pulse clear during SCAN (piece_cnt=3) -> no res_valid. A fresh 4-row L rot 0 load (0000,0010,1110,0000) then returns idx=L, rot=0 at T+4.

Source files
------------

// File: rtl/tetromino_shape_matcher.sv
// ---------------------------------------------------------------------------
// tetromino_shape_matcher
//
// Recovers piece identity from a captured 4x4 window. Four bitmap rows are
// taken over a valid/ready stream (top row first, bit 3 = leftmost column).
// The block then walks the seven tetromino tables, one piece per cycle, and
// tests all four rotations of that piece at once. The first hit, or a miss
// after the last piece, is held on the result stream until it is accepted.
//
// This file also carries the shared tetromino definitions (index type, table
// type, index macros) and the table ROM get_tetromino_info.
//
// Ports (tetromino_shape_matcher):
//   clk, rst_n            clock, asynchronous active-low reset
//   clear                 synchronous abort back to LOAD
//   row_valid/row_ready   row handshake; row_data = one 4-bit bitmap row
//   res_valid/res_ready   result handshake
//   res_found             1 = exact match found
//   res_idx               matched piece (I when nothing matched)
//   res_rot               matched rotation 0..3 (0 when nothing matched)
// ---------------------------------------------------------------------------

`ifndef TETROMINO_I_IDX
`define TETROMINO_I_IDX 3'd0
`define TETROMINO_J_IDX 3'd1
`define TETROMINO_L_IDX 3'd2
`define TETROMINO_O_IDX 3'd3
`define TETROMINO_S_IDX 3'd4
`define TETROMINO_T_IDX 3'd5
`define TETROMINO_Z_IDX 3'd6
`endif

package tetromino_pkg;
    typedef struct packed {
        logic [2:0] data;
    } tetromino_idx_t;

    // Rotation r lives in bits [63-16r : 48-16r]; row 0 is the top nibble.
    typedef logic [63:0] tetromino_t;
endpackage

// Table ROM: piece index in, all four rotations out.
module get_tetromino_info
    import tetromino_pkg::*;
(
    input  tetromino_idx_t idx,
    output tetromino_t     tetromino
);
    always_comb begin
        tetromino = '0;
        case (idx.data)
            `TETROMINO_I_IDX: tetromino = 64'h0F00_2222_00F0_4444;
            `TETROMINO_J_IDX: tetromino = 64'h08E0_0644_00E2_044C;
            `TETROMINO_L_IDX: tetromino = 64'h02E0_0446_00E8_0C44;
            `TETROMINO_O_IDX: tetromino = 64'h0660_0660_0660_0660;
            `TETROMINO_S_IDX: tetromino = 64'h06C0_0462_006C_08C4;
            `TETROMINO_T_IDX: tetromino = 64'h04E0_0464_00E4_04C4;
            `TETROMINO_Z_IDX: tetromino = 64'h0C60_0264_00C6_04C8;
            default:          tetromino = '0;
        endcase
    end
endmodule

module tetromino_shape_matcher
    import tetromino_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clear,
    input  logic           row_valid,
    output logic           row_ready,
    input  logic [3:0]     row_data,
    output logic           res_valid,
    input  logic           res_ready,
    output logic           res_found,
    output tetromino_idx_t res_idx,
    output logic [1:0]     res_rot
);
    typedef enum logic [1:0] {LOAD, SCAN, DONE} state_t;

    state_t         state;
    logic [1:0]     row_cnt;
    logic [2:0]     piece_cnt;
    logic [15:0]    bitmap;

    tetromino_idx_t scan_idx;
    tetromino_t     info;
    logic [3:0]     hit;
    logic [1:0]     hit_rot;

    // Scan order I, J, L, O, S, T, Z.
    always_comb begin
        scan_idx.data = `TETROMINO_I_IDX;
        case (piece_cnt)
            3'd0:    scan_idx.data = `TETROMINO_I_IDX;
            3'd1:    scan_idx.data = `TETROMINO_J_IDX;
            3'd2:    scan_idx.data = `TETROMINO_L_IDX;
            3'd3:    scan_idx.data = `TETROMINO_O_IDX;
            3'd4:    scan_idx.data = `TETROMINO_S_IDX;
            3'd5:    scan_idx.data = `TETROMINO_T_IDX;
            default: scan_idx.data = `TETROMINO_Z_IDX;
        endcase
    end

    get_tetromino_info u_info (
        .idx       (scan_idx),
        .tetromino (info)
    );

    // Every table entry has exactly four set bits, so exact equality already
    // rejects bitmaps with any other population count.
    always_comb begin
        hit = '0;
        for (int r = 0; r < 4; r++)
            hit[r] = (bitmap == info[63-16*r -: 16]);
    end

    // Lowest matching rotation wins (O repeats itself, so it reports 0).
    always_comb begin
        hit_rot = 2'd0;
        if      (hit[0]) hit_rot = 2'd0;
        else if (hit[1]) hit_rot = 2'd1;
        else if (hit[2]) hit_rot = 2'd2;
        else if (hit[3]) hit_rot = 2'd3;
    end

    assign row_ready = (state == LOAD);
    assign res_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= LOAD;
            row_cnt      <= '0;
            piece_cnt    <= '0;
            bitmap       <= '0;
            res_found    <= 1'b0;
            res_idx.data <= `TETROMINO_I_IDX;
            res_rot      <= '0;
        end else if (clear) begin
            state        <= LOAD;
            row_cnt      <= '0;
            piece_cnt    <= '0;
            bitmap       <= '0;
            res_found    <= 1'b0;
            res_idx.data <= `TETROMINO_I_IDX;
            res_rot      <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (row_valid) begin
                        case (row_cnt)
                            2'd0:    bitmap[15:12] <= row_data;
                            2'd1:    bitmap[11:8]  <= row_data;
                            2'd2:    bitmap[7:4]   <= row_data;
                            default: bitmap[3:0]   <= row_data;
                        endcase
                        row_cnt <= row_cnt + 2'd1;  // wraps to 0 after slot 3
                        if (row_cnt == 2'd3) begin
                            piece_cnt <= '0;
                            state     <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    if (|hit) begin
                        res_found <= 1'b1;
                        res_idx   <= scan_idx;
                        res_rot   <= hit_rot;
                        state     <= DONE;
                    end else if (piece_cnt == 3'd6) begin
                        res_found    <= 1'b0;
                        res_idx.data <= `TETROMINO_I_IDX;
                        res_rot      <= '0;
                        state        <= DONE;
                    end else begin
                        piece_cnt <= piece_cnt + 3'd1;
                    end
                end
                DONE: begin
                    if (res_ready)
                        state <= LOAD;
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_tetromino_shape_matcher.sv
// ---------------------------------------------------------------------------
// tb_tetromino_shape_matcher
//
// Directed bench. The stimulus process loads bitmaps and pushes the expected
// result (found, idx, rot, latency from the last row) into a queue; the monitor
// pops on every result handshake and compares, and also checks that results
// stay stable and row_ready stays low while a result is pending.
// ---------------------------------------------------------------------------
module tb_tetromino_shape_matcher;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    logic       row_valid;
    logic       row_ready;
    logic [3:0] row_data;
    logic       res_valid;
    logic       res_ready;
    logic       res_found;
    logic [2:0] res_idx;
    logic [1:0] res_rot;

    always #5 clk = ~clk;

    tetromino_shape_matcher dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .row_valid (row_valid),
        .row_ready (row_ready),
        .row_data  (row_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_found (res_found),
        .res_idx   (res_idx),
        .res_rot   (res_rot)
    );

    typedef struct {
        int     found;
        int     idx;
        int     rot;
        int     lat;
        longint t;
    } exp_t;

    exp_t   q[$];
    longint cyc = 0;
    int     n_checks = 0;
    int     n_pass = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor / scoreboard.
    initial begin
        bit         seen = 0;
        longint     rise = 0;
        logic       p_found;
        logic [2:0] p_idx;
        logic [1:0] p_rot;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (rst_n && res_valid) begin
                if (!seen) begin
                    seen = 1;
                    rise = cyc;
                end else begin
                    chk("hold_found", res_found, p_found);
                    chk("hold_idx", res_idx, p_idx);
                    chk("hold_rot", res_rot, p_rot);
                end
                chk("done_row_ready", row_ready, 0);
                p_found = res_found;
                p_idx   = res_idx;
                p_rot   = res_rot;
                if (res_ready) begin
                    if (q.size() == 0) begin
                        chk("unexpected_result", 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk("res_found", res_found, e.found);
                        chk("res_idx", res_idx, e.idx);
                        chk("res_rot", res_rot, e.rot);
                        chk("latency", rise - e.t, e.lat);
                    end
                    seen = 0;
                end
            end else begin
                seen = 0;
            end
        end
    end

    // Present the rows of bm (top row in bits 15:12); pat gives the row_valid
    // pattern for the first plen beats, then row_valid stays high. Stops after
    // stop_after handshakes; t_hs is the cycle of the last one.
    task automatic load(input logic [15:0] bm, input logic [15:0] pat, input int plen,
                        input int stop_after, output longint t_hs);
        int k = 0;
        int beat = 0;
        t_hs = -1;
        while (k < stop_after && beat < 60) begin
            @(posedge clk); #1;
            row_valid = (beat < plen) ? pat[plen-1-beat] : 1'b1;
            row_data  = bm[15-4*k -: 4];
            beat++;
            @(negedge clk);
            if (row_valid && row_ready) begin
                t_hs = cyc;
                k++;
            end
        end
        @(posedge clk); #1;
        row_valid = 1'b0;
        if (k < stop_after) chk("load_timeout", k, stop_after);
    endtask

    task automatic run(input logic [15:0] bm, input int found, input int idx,
                       input int rot, input int lat);
        exp_t   e;
        longint t;
        load(bm, 16'h0, 0, 4, t);
        e.found = found; e.idx = idx; e.rot = rot; e.lat = lat; e.t = t;
        q.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic idle_no_result(input string name, input int cycles);
        int seen_valid = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (res_valid) seen_valid++;
        end
        chk(name, seen_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        longint t;
        exp_t   e;
        int     n;

        rst_n = 1'b0; clear = 1'b0; row_valid = 1'b0; row_data = 4'h0; res_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_row_ready", row_ready, 1);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_found", res_found, 0);
        chk("rst_res_idx", res_idx, 0);
        chk("rst_res_rot", res_rot, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // found, idx, rot, latency
        run(16'h2222, 1, 0, 1, 2); drain();   // I rot 1
        run(16'h04C8, 1, 6, 3, 8); drain();   // Z rot 3
        run(16'h0660, 1, 3, 0, 5); drain();   // O
        run(16'h00E4, 1, 5, 2, 7); drain();   // T rot 2
        run(16'hFF00, 0, 0, 0, 8); drain();   // 8 bits set: no match
        run(16'h0000, 0, 0, 0, 8); drain();   // empty

        // Backpressure: J rot 1 held for 5 cycles with row_valid toggling.
        res_ready = 1'b0;
        run(16'h0644, 1, 1, 1, 3);
        n = 0;
        while (!res_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp_res_valid_rise", res_valid, 1);
        repeat (5) begin
            @(posedge clk); #1;
            row_valid = ~row_valid;
            row_data  = 4'hF;
            @(negedge clk);
            chk("bp_row_ready", row_ready, 0);
            chk("bp_res_valid", res_valid, 1);
        end
        @(posedge clk); #1;
        row_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;          // handshake taken on this edge
        @(negedge clk);
        chk("bp_row_ready_after", row_ready, 1);
        chk("bp_res_valid_after", res_valid, 0);
        drain();

        // Gappy row stream carrying I rot 0.
        load(16'h0F00, 16'b1001101, 7, 4, t);
        e.found = 1; e.idx = 0; e.rot = 0; e.lat = 2; e.t = t;
        q.push_back(e);
        drain();

        // Reset after two rows: partial load discarded, nothing emitted.
        load(16'h00E4, 16'h0, 0, 2, t);
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        chk("abort_rst_row_ready", row_ready, 1);
        @(posedge clk); #1 rst_n = 1'b1;
        idle_no_result("abort_rst_no_result", 12);

        // Clear while piece 3 is being compared (Z would only hit at piece 6).
        load(16'h04C8, 16'h0, 0, 4, t);   // returns 1 ns into cycle t+1
        repeat (3) @(posedge clk);
        #1 clear = 1'b1;                  // cycle t+4
        @(posedge clk); #1 clear = 1'b0;
        @(negedge clk);
        chk("abort_clr_row_ready", row_ready, 1);
        idle_no_result("abort_clr_no_result", 12);

        // Fresh L rot 0 load after both aborts.
        run(16'h02E0, 1, 2, 0, 4); drain();

        chk("final_queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
